// File: rtl/seq_det_param.sv
// seq_det_param: parametrised Mealy detector for an MSB-first SEQ_LEN-bit pattern, with run-time overlap select.
// Build with SEQ_DET_COUNT_EN defined to include the saturating match counter (Cnt/Clr); otherwise Cnt reads 0.
module seq_det_param #(
   parameter int                 SEQ_LEN = 4,
   parameter logic [SEQ_LEN-1:0] SEQ     = 4'b1010,
   parameter int                 CNT_W   = 8,
   parameter int                 ST_W    = $clog2(SEQ_LEN)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             In,
   input  logic             En,
   input  logic             Ovl,
   input  logic             Clr,
   output logic             OP,
   output logic [ST_W-1:0]  CS,
   output logic [ST_W-1:0]  NS,
   output logic [CNT_W-1:0] Cnt
);

   // Longest pattern prefix that is a proper-or-equal suffix (length <= k) of
   // the first k pattern bits followed by bit b; evaluated only at elaboration.
   function automatic int border(input int k, input int b);
      int pref_k;
      int str;
      int best;
      best   = 0;
      pref_k = int'(SEQ) >> (SEQ_LEN - k);
      str    = (pref_k << 1) | b;
      for (int l = 1; l <= k; l++) begin
         if ((str & ((32'sd1 << l) - 32'sd1)) == (int'(SEQ) >> (SEQ_LEN - l))) begin
            best = l;
         end else begin
            best = best;
         end
      end
      return best;
   endfunction

   localparam logic [ST_W-1:0] LAST_ST = ST_W'(SEQ_LEN - 1);
   localparam logic [ST_W-1:0] F_FULL  = ST_W'(border(SEQ_LEN - 1, int'(SEQ[0])));

   logic [SEQ_LEN-1:0] exp_tbl;
   logic [ST_W-1:0]    fb_tbl [SEQ_LEN];
   logic [ST_W-1:0]    state_q, state_d;
   logic               op_s;
   logic               exp_bit_s;

   for (genvar k = 0; k < SEQ_LEN; k++) begin : g_tbl
      localparam int FB_K = border(k, 1 - int'(SEQ[SEQ_LEN-1-k]));
      assign exp_tbl[k] = SEQ[SEQ_LEN-1-k];
      assign fb_tbl[k]  = ST_W'(FB_K);
   end

   // Next-state and Mealy detect; mismatches fall back via the elaborated table.
   always_comb begin
      op_s      = 1'b0;
      state_d   = state_q;
      exp_bit_s = exp_tbl[state_q];
      if (!En) begin
         state_d = state_q;
      end else if (In == exp_bit_s) begin
         if (state_q == LAST_ST) begin
            op_s    = 1'b1;
            state_d = Ovl ? F_FULL : '0;
         end else begin
            state_d = state_q + ST_W'(1);
         end
      end else begin
         state_d = fb_tbl[state_q];
      end
   end

   // State register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   assign OP = op_s;
   assign CS = state_q;
   assign NS = state_d;

`ifdef SEQ_DET_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating detection count; clear wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (Clr) begin
         cnt_d = '0;
      end else if (op_s && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign Cnt = cnt_q;
`else
   logic unused_clr;
   assign unused_clr = Clr;
   assign Cnt        = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench for seq_det_param: two instances (1010/CNT_W=2 and 11011/CNT_W=3) against a bit-history model.
module tb_seq_det_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_b = 1'b0;
   logic       en = 1'b0;
   logic       ovl = 1'b0;
   logic       clr = 1'b0;
   logic       op_a, op_b;
   logic [1:0] cs_a, ns_a, cnt_a;
   logic [2:0] cs_b, ns_b, cnt_b;

   always #5 clk = ~clk;

   seq_det_param #(.SEQ_LEN(4), .SEQ(4'b1010), .CNT_W(2)) u_dut_a (
      .Clk(clk), .Rst(rst_n), .In(in_b), .En(en), .Ovl(ovl), .Clr(clr),
      .OP(op_a), .CS(cs_a), .NS(ns_a), .Cnt(cnt_a));

   seq_det_param #(.SEQ_LEN(5), .SEQ(5'b11011), .CNT_W(3)) u_dut_b (
      .Clk(clk), .Rst(rst_n), .In(in_b), .En(en), .Ovl(ovl), .Clr(clr),
      .OP(op_b), .CS(cs_b), .NS(ns_b), .Cnt(cnt_b));

   typedef struct { int op_a; int ns_a; int op_b; int ns_b; } comb_t;
   typedef struct { int cs_a; int cnt_a; int cs_b; int cnt_b; } st_t;

   comb_t comb_q[$];
   st_t   st_q[$];
   int    checks = 0;
   int    errors = 0;

   // Reference model: raw history of accepted bits per instance.
   int PLEN [2] = '{4, 5};
   int PAT  [2] = '{10, 27};
   int CMAX [2] = '{3, 7};
   int hist [2] = '{0, 0};
   int hlen [2] = '{0, 0};
   int mcnt [2] = '{0, 0};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // True when the last l accepted bits equal the first l pattern bits.
   function automatic bit ends_with(input int d, input int l);
      if (hlen[d] < l) return 1'b0;
      return (hist[d] & ((1 << l) - 1)) == (PAT[d] >> (PLEN[d] - l));
   endfunction

   function automatic int state_of(input int d);
      for (int l = PLEN[d] - 1; l > 0; l--) begin
         if (ends_with(d, l)) return l;
      end
      return 0;
   endfunction

   function automatic void model_clear();
      for (int d = 0; d < 2; d++) begin
         hist[d] = 0;
         hlen[d] = 0;
         mcnt[d] = 0;
      end
   endfunction

   function automatic void step(input int d, input bit inb, input bit e, input bit o, input bit c,
                                output int op, output int ns);
      op = 0;
      if (e) begin
         hist[d] = ((hist[d] << 1) | int'(inb)) & 32'hFFFF;
         if (hlen[d] < 16) hlen[d]++;
         op = ends_with(d, PLEN[d]) ? 1 : 0;
         if (op == 1 && !o) begin
            hist[d] = 0;
            hlen[d] = 0;
         end
      end
      ns = state_of(d);
`ifdef SEQ_DET_COUNT_EN
      if (c) mcnt[d] = 0;
      else if (op == 1 && mcnt[d] < CMAX[d]) mcnt[d]++;
`else
      mcnt[d] = 0;
`endif
   endfunction

   task automatic push_expect(input bit inb, input bit e, input bit o, input bit c);
      comb_t ce;
      st_t   se;
      step(0, inb, e, o, c, ce.op_a, ce.ns_a);
      step(1, inb, e, o, c, ce.op_b, ce.ns_b);
      se.cs_a  = ce.ns_a;
      se.cs_b  = ce.ns_b;
      se.cnt_a = mcnt[0];
      se.cnt_b = mcnt[1];
      comb_q.push_back(ce);
      st_q.push_back(se);
   endtask

   task automatic drive(input bit inb, input bit e, input bit o, input bit c);
      @(negedge clk);
      in_b = inb; en = e; ovl = o; clr = c;
      push_expect(inb, e, o, c);
   endtask

   task automatic drive_bits(input logic [15:0] bits, input int n, input bit o);
      logic [15:0] v;
      v = bits;
      for (int i = n - 1; i >= 0; i--) drive(v[i], 1'b1, o, 1'b0);
   endtask

   // Asynchronous reset pulse between edges; the bit on In is the first after release.
   task automatic rst_pulse(input bit inb);
      @(negedge clk);
      rst_n = 1'b0;
      model_clear();
      in_b = inb; en = 1'b1; clr = 1'b0;
      push_expect(inb, 1'b1, ovl, 1'b0);
      #1;
      chk("rst_cs_a", int'(cs_a), 0);
      chk("rst_cs_b", int'(cs_b), 0);
      chk("rst_op_a", int'(op_a), 0);
      chk("rst_cnt_a", int'(cnt_a), 0);
      #2;
      rst_n = 1'b1;
   endtask

   // Monitor: combinational outputs mid-low-phase, registered outputs after the edge.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (comb_q.size() > 0) begin
            comb_t ce;
            ce = comb_q.pop_front();
            chk("op_a", int'(op_a), ce.op_a);
            chk("ns_a", int'(ns_a), ce.ns_a);
            chk("op_b", int'(op_b), ce.op_b);
            chk("ns_b", int'(ns_b), ce.ns_b);
         end
         @(posedge clk);
         #1;
         if (st_q.size() > 0) begin
            st_t se;
            se = st_q.pop_front();
            chk("cs_a", int'(cs_a), se.cs_a);
            chk("cnt_a", int'(cnt_a), se.cnt_a);
            chk("cs_b", int'(cs_b), se.cs_b);
            chk("cnt_b", int'(cnt_b), se.cnt_b);
         end
      end
   end

   initial begin
      bit o_r;
      #2;
      chk("init_cs_a", int'(cs_a), 0);
      chk("init_cnt_a", int'(cnt_a), 0);
      chk("init_cs_b", int'(cs_b), 0);
      chk("init_cnt_b", int'(cnt_b), 0);
      #10;
      rst_n = 1'b1;

      drive_bits(16'b101010, 6, 1'b0);
      drive_bits(16'b101, 3, 1'b0);
      rst_pulse(1'b0);
      drive_bits(16'b101010, 6, 1'b1);
      rst_pulse(1'b0);
      drive_bits(16'b1011010, 7, 1'b0);
      drive_bits(16'b11010, 5, 1'b0);
      rst_pulse(1'b0);
      drive_bits(16'b10, 2, 1'b0);
      for (int i = 0; i < 3; i++) drive(i[0], 1'b0, 1'b0, 1'b0);
      drive_bits(16'b10, 2, 1'b0);
      rst_pulse(1'b0);
      drive_bits(16'b1010101010, 10, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      drive_bits(16'b11011011011, 11, 1'b1);
      drive_bits(16'b11011011011, 11, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b1);

      o_r = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 19) == 0) o_r = ~o_r;
         if ($urandom_range(0, 99) == 0) rst_pulse(1'($urandom_range(0, 1)));
         else drive(1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0, o_r,
                    $urandom_range(0, 29) == 0);
      end

      repeat (3) @(negedge clk);
      chk("queues_drained", comb_q.size() + st_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised Mealy sequence detector: a configurable successor to the fixed 1010 detectors. It matches an arbitrary SEQ_LEN-bit pattern on a serial input, MSB first, and supports overlapping and non-overlapping modes selected at run time. It also provides a clock-enable and an optional saturating match counter. It sits in the FSM library as the general-purpose detector used by higher-level protocol blocks and benches.

## Interface
- SEQ_LEN, 4, pattern length in bits; legal range 2..16
- SEQ, 4'b1010, pattern; bit SEQ_LEN-1 is received first
- CNT_W, 8, match-counter width; legal range 1..16
- ST_W, $clog2(SEQ_LEN), state width (derived; not overridden)

- Clk  input  1  clock; rising edge active
- Rst  input  1  asynchronous reset, active-low
- In   input  1  serial data bit
- En   input  1  bit-valid / clock enable; when 0 the state holds and OP=0
- Ovl  input  1  1 = overlapping, 0 = non-overlapping; sampled every cycle
- Clr  input  1  synchronous clear of Cnt (priority over increment)
- OP   output 1  Mealy detect; combinational, high in the cycle the final pattern bit is presented
- CS   output ST_W  current state = number of pattern bits matched (0..SEQ_LEN-1)
- NS   output ST_W  next state (combinational, debug)
- Cnt  output CNT_W  saturating count of detections

## Operation
- State k means the last k accepted bits equal the first k pattern bits: SEQ[SEQ_LEN-1 -: k].
- Expected bit in state k: E = SEQ[SEQ_LEN-1-k].
- En=0: NS=CS and OP=0. In, Ovl and Clr still act on Cnt per the rules below.
- En=1, In==E, k<SEQ_LEN-1: NS=k+1 and OP=0.
- En=1, In==E, k==SEQ_LEN-1: OP=1 (full match).
  - Ovl=1: NS = F(SEQ_LEN), where F(j) is the length of the longest proper prefix of the pattern that is also a suffix of its first j bits.
  - Ovl=0: NS=0.
- En=1, In!=E: OP=0. NS = length of the longest pattern prefix that is a suffix of (matched k bits followed by In), computed KMP-style. This rule is the same in both modes.
- The fallback table is computed at elaboration from SEQ; no run-time pattern load.
- Ovl is evaluated only at the match transition. Changing it mid-pattern takes effect at the next full match.
- Cnt update on a rising edge:
  - Clr=1 → 0.
  - Otherwise OP=1 and Cnt != all-ones → Cnt+1.
  - Otherwise hold; Cnt saturates at 2^CNT_W-1.
- Reset (Rst=0, asynchronous): CS=0, Cnt=0. OP therefore reads 0, since SEQ_LEN≥2 means no match is possible from state 0. NS follows In combinationally.
- Reset asserted mid-pattern discards partial progress. The first bit after release is treated as pattern bit 0.

## Timing
- Detection latency: 0 cycles. OP is asserted combinationally while the last bit is on In, before the capturing edge. Consumers sample OP at that edge.
- State update: 1 cycle. CS takes NS on the rising edge when Rst=1.
- Cnt reflects a detection 1 cycle after OP is high.
- OP is a single-cycle pulse per match. Back-to-back OP cycles are possible only when F(SEQ_LEN)=SEQ_LEN-1, e.g. pattern 1111 with Ovl=1.
- Inputs must meet setup to Clk. Rst release must be synchronised externally.

## Configuration
- SEQ_DET_COUNT_EN defined: the Cnt register, Clr and the saturation logic are present as described.
- SEQ_DET_COUNT_EN undefined: no counter flops. Cnt is tied to 0, Clr is ignored, and OP/CS/NS behaviour is unchanged.

## Test plan
- Default SEQ=1010, Ovl=0, En=1, stream 1,0,1,0,1,0 → OP high on bit 4 only; CS after each edge is 1,2,3,0,1,2; Cnt=1.
- Same stream with Ovl=1 → OP on bits 4 and 6; CS after bit 4 = 2; Cnt=2.
- Mismatch fallback, Ovl=0, stream 1,0,1,1,0,1,0 → CS after bit 4 = 1; OP on bit 7 only. Stream 1,1,0,1,0 → OP on bit 5.
- Reset mid-pattern: feed 1,0,1 (CS=3), pulse Rst low for 3 ns between edges, then feed 0 → CS=0 immediately on Rst low; no OP; CS=0 after the edge.
- En stall, Ovl=0: 1,0, then En=0 for 3 cycles with In toggling, then En=1 with 1,0 → CS holds at 2 during the stall; OP on the final bit.
- SEQ_DET_COUNT_EN defined, CNT_W=2, Ovl=1, stream 1010101010 (4 matches) → Cnt goes 1,2,3,3. Clr=1 for one cycle → Cnt=0 next edge. Build without the macro → Cnt stays 0.
